instruction_decoder: RTL and testbench

Registered 8-bit instruction decoder for the CPU front end. Classifies each instruction by its two top bits into one of four one-hot modes (immediate, compute, copy, condition) and extracts the operand fields each mode needs. Sits between instruction fetch and the register-file/ALU/branch control logic, with one clock of latency.

---
 rtl/instruction_decoder.sv | 70 +++++++
 tb/tb_instruction_decoder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// Registered 8-bit instruction decoder: classifies by opcode bits [7:6] into a
// one-hot mode and presents the operand fields one clock after capture.
module instruction_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instruction,
  input  logic       instr_valid,
  output logic       out_valid,
  output logic       mode0,
  output logic       mode1,
  output logic       mode2,
  output logic       mode3,
  output logic [5:0] imm,
  output logic [2:0] alu_op,
  output logic [2:0] src,
  output logic [2:0] dst,
  output logic [2:0] cond
);

  logic [5:0] operand_q, operand_d;
  logic [3:0] mode_q, mode_d;
  logic       valid_q, valid_d;

  function automatic logic [3:0] decode_mode(input logic [1:0] opcode);
    logic [3:0] onehot;
    onehot = 4'b0000;
    case (opcode)
      2'b00:   onehot = 4'b0001;
      2'b01:   onehot = 4'b0010;
      2'b10:   onehot = 4'b0100;
      default: onehot = 4'b1000;
    endcase
    return onehot;
  endfunction

  always_comb begin
    operand_d = operand_q;
    mode_d    = mode_q;
    valid_d   = instr_valid;
    if (instr_valid) begin
      operand_d = instruction[5:0];
      mode_d    = decode_mode(instruction[7:6]);
    end
  end

  // Mode is held in its own register so reset can leave no mode asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_q <= 6'd0;
      mode_q    <= 4'b0000;
      valid_q   <= 1'b0;
    end else begin
      operand_q <= operand_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign mode0     = mode_q[0];
  assign mode1     = mode_q[1];
  assign mode2     = mode_q[2];
  assign mode3     = mode_q[3];
  assign imm       = operand_q;
  assign alu_op    = operand_q[2:0];
  assign src       = operand_q[5:3];
  assign dst       = operand_q[2:0];
  assign cond      = operand_q[2:0];

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed and exhaustive self-checking bench for instruction_decoder.
module tb_instruction_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] instruction;
  logic       instr_valid;
  logic       out_valid;
  logic       mode0, mode1, mode2, mode3;
  logic [5:0] imm;
  logic [2:0] alu_op, src, dst, cond;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .out_valid   (out_valid),
    .mode0       (mode0),
    .mode1       (mode1),
    .mode2       (mode2),
    .mode3       (mode3),
    .imm         (imm),
    .alu_op      (alu_op),
    .src         (src),
    .dst         (dst),
    .cond        (cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed layout: {out_valid, mode3..mode0, imm, alu_op, src, dst, cond}
  function automatic logic [22:0] pack(input logic ov, input logic [3:0] m,
                                       input logic [5:0] i, input logic [2:0] a,
                                       input logic [2:0] s, input logic [2:0] d,
                                       input logic [2:0] c);
    return {ov, m, i, a, s, d, c};
  endfunction

  function automatic logic [22:0] model(input logic [7:0] ins);
    logic [3:0] m;
    case (ins[7:6])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0010;
      2'b10:   m = 4'b0100;
      default: m = 4'b1000;
    endcase
    return pack(1'b1, m, ins[5:0], ins[2:0], ins[5:3], ins[2:0], ins[2:0]);
  endfunction

  task automatic check(input string name, input logic [22:0] exp);
    logic [22:0] got;
    got = {out_valid, mode3, mode2, mode1, mode0, imm, alu_op, src, dst, cond};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %06h expected %06h", name, got, exp);
  endtask

  task automatic step(input logic [7:0] ins, input logic vld);
    @(negedge clk);
    instruction = ins;
    instr_valid = vld;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  ins;
    logic        vld;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"sweep_m0", 8'h00, 1'b1, pack(1'b1, 4'b0001, 6'd0,  3'd0, 3'd0, 3'd0, 3'd0)};
    vecs[1]  = '{"sweep_m1", 8'h40, 1'b1, pack(1'b1, 4'b0010, 6'd0,  3'd0, 3'd0, 3'd0, 3'd0)};
    vecs[2]  = '{"sweep_m2", 8'h80, 1'b1, pack(1'b1, 4'b0100, 6'd0,  3'd0, 3'd0, 3'd0, 3'd0)};
    vecs[3]  = '{"sweep_m3", 8'hC0, 1'b1, pack(1'b1, 4'b1000, 6'd0,  3'd0, 3'd0, 3'd0, 3'd0)};
    vecs[4]  = '{"imm45",    8'h2D, 1'b1, pack(1'b1, 4'b0001, 6'd45, 3'd5, 3'd5, 3'd5, 3'd5)};
    vecs[5]  = '{"alu6",     8'h46, 1'b1, pack(1'b1, 4'b0010, 6'd6,  3'd6, 3'd0, 3'd6, 3'd6)};
    vecs[6]  = '{"copy35",   8'h9D, 1'b1, pack(1'b1, 4'b0100, 6'd29, 3'd5, 3'd3, 3'd5, 3'd5)};
    vecs[7]  = '{"cond2",    8'hC2, 1'b1, pack(1'b1, 4'b1000, 6'd2,  3'd2, 3'd0, 3'd2, 3'd2)};
    vecs[8]  = '{"copy_again", 8'h9D, 1'b1, pack(1'b1, 4'b0100, 6'd29, 3'd5, 3'd3, 3'd5, 3'd5)};
    vecs[9]  = '{"hold1",    8'h00, 1'b0, pack(1'b0, 4'b0100, 6'd29, 3'd5, 3'd3, 3'd5, 3'd5)};
    vecs[10] = '{"hold2",    8'hFF, 1'b0, pack(1'b0, 4'b0100, 6'd29, 3'd5, 3'd3, 3'd5, 3'd5)};

    // Reset asserted with a valid all-ones instruction present
    rst_n       = 1'b0;
    instruction = 8'hFF;
    instr_valid = 1'b1;
    #1;
    check("reset_immediate", 23'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 23'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].ins, vecs[i].vld);
      check(vecs[i].name, vecs[i].exp);
    end

    // Async reset between edges right after a mode3 decode
    step(8'hC2, 1'b1);
    check("pre_reset_m3", pack(1'b1, 4'b1000, 6'd2, 3'd2, 3'd0, 3'd2, 3'd2));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 23'd0);
    instruction = 8'hFF;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ignores_valid", 23'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h40, 1'b1);
    check("post_reset_m1", pack(1'b1, 4'b0010, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0));

    // Exhaustive back-to-back sweep
    for (int v = 0; v < 256; v++) begin
      logic [7:0] ins;
      ins = v[7:0];
      step(ins, 1'b1);
      check($sformatf("exh_%02h", ins), model(ins));
    end

    step(8'h00, 1'b0);
    check("final_hold", pack(1'b0, 4'b1000, 6'd63, 3'd7, 3'd7, 3'd7, 3'd7));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
